// File: rtl/fpu_flt2int.sv
// fpu_flt2int
// Multi-cycle single-precision float to 32-bit integer converter
// (FCVT.W.S / FCVT.WU.S). The significand is aligned one bit per cycle,
// then rounded according to flt_rm in a single ROUND cycle.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active low
//   start          in   launch a conversion (sampled only in IDLE)
//   opa[31:0]      in   IEEE-754 single operand
//   ID_EX_alu_func in   ALU_FCVTWS = signed, ALU_FCVTWUS = unsigned
//   flt_rm[2:0]    in   rounding mode (RNE/RTZ/RDN/RUP/RMM, 101-111 -> RNE)
//   res[31:0]      out  integer result, held until next conversion ends
//   nv, nx         out  invalid / inexact flags, held with res
//   busy           out  high in ALIGN and ROUND
//   valid          out  one-cycle pulse in DONE
//
// state | meaning
// IDLE  | waiting for start
// ALIGN | shifting magnitude one bit per cycle, cnt_q steps left
// ROUND | apply rounding increment, saturate, register result
// DONE  | valid pulse, result on res
module fpu_flt2int (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [4:0]  ID_EX_alu_func,
  input  logic [2:0]  flt_rm,
  output logic [31:0] res,
  output logic        nv,
  output logic        nx,
  output logic        busy,
  output logic        valid
);

  localparam logic [4:0] ALU_FCVTWS  = 5'd24;
  localparam logic [4:0] ALU_FCVTWUS = 5'd25;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] mag_q, mag_d;
  logic        g_q, g_d;
  logic        s_q, s_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic        special_q, special_d;
  logic        ovf_q, ovf_d;
  logic        left_q, left_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;

  logic [7:0]  op_exp;
  logic [22:0] op_mant;
  logic [7:0]  lshift;
  logic [7:0]  rshift;
  logic        inc;
  logic [32:0] m;
  logic        invalid;

  assign op_exp  = opa[30:23];
  assign op_mant = opa[22:0];
  // Exponent 150 is E = 23: significand already aligned to integer weight.
  assign lshift  = op_exp - 8'd150;
  assign rshift  = 8'd150 - op_exp;

  always_comb begin
    inc = 1'b0;
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (g_q | s_q) & sign_q;
      RM_RUP:  inc = (g_q | s_q) & ~sign_q;
      RM_RMM:  inc = g_q;
      default: inc = g_q & (s_q | mag_q[0]);
    endcase
    m = mag_q + {32'd0, inc};
    if (uns_q)
      invalid = special_q | ovf_q | m[32] | (sign_q & (m != 33'd0));
    else
      invalid = special_q | ovf_q
              | (~sign_q & (m > 33'h0_7FFF_FFFF))
              | ( sign_q & (m > 33'h0_8000_0000));
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    g_d       = g_q;
    s_d       = s_q;
    sign_d    = sign_q;
    uns_d     = uns_q;
    rm_d      = rm_q;
    special_d = special_q;
    ovf_d     = ovf_q;
    left_d    = left_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    nv_d      = nv_q;
    nx_d      = nx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // NaN converts as +infinity, so its sign is dropped here.
          sign_d    = opa[31] & ~((op_exp == 8'hFF) & (op_mant != 23'd0));
          uns_d     = (ID_EX_alu_func == ALU_FCVTWUS);
          rm_d      = flt_rm;
          special_d = (op_exp == 8'hFF);
          ovf_d     = (op_exp >= 8'd159) & (op_exp != 8'hFF);
          mag_d     = {9'd0, (op_exp != 8'd0), op_mant};
          g_d       = 1'b0;
          s_d       = 1'b0;
          left_d    = (op_exp >= 8'd150);
          cnt_d     = 5'd0;
          if (op_exp >= 8'd159) begin
            state_d = ROUND;
          end else if (op_exp <= 8'd125) begin
            // |x| < 0.5: only the sticky bit survives.
            mag_d   = 33'd0;
            s_d     = (opa[30:0] != 31'd0);
            state_d = ROUND;
          end else begin
            cnt_d   = (op_exp >= 8'd150) ? lshift[4:0] : rshift[4:0];
            state_d = ((op_exp >= 8'd150) && (lshift == 8'd0)) ? ROUND : ALIGN;
          end
        end
      end
      ALIGN: begin
        if (left_q) begin
          mag_d = {mag_q[31:0], 1'b0};
        end else begin
          s_d   = s_q | g_q;
          g_d   = mag_q[0];
          mag_d = {1'b0, mag_q[32:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1)
          state_d = ROUND;
      end
      ROUND: begin
        nv_d = invalid;
        nx_d = (g_q | s_q) & ~invalid;
        if (invalid) begin
          if (uns_q)
            res_d = sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
          else
            res_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (sign_q && !uns_q) begin
          res_d = 32'd0 - m[31:0];
        end else begin
          res_d = m[31:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mag_q     <= 33'd0;
      g_q       <= 1'b0;
      s_q       <= 1'b0;
      sign_q    <= 1'b0;
      uns_q     <= 1'b0;
      rm_q      <= 3'd0;
      special_q <= 1'b0;
      ovf_q     <= 1'b0;
      left_q    <= 1'b0;
      cnt_q     <= 5'd0;
      res_q     <= 32'd0;
      nv_q      <= 1'b0;
      nx_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      g_q       <= g_d;
      s_q       <= s_d;
      sign_q    <= sign_d;
      uns_q     <= uns_d;
      rm_q      <= rm_d;
      special_q <= special_d;
      ovf_q     <= ovf_d;
      left_q    <= left_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      nv_q      <= nv_d;
      nx_q      <= nx_d;
    end
  end

  assign res   = res_q;
  assign nv    = nv_q;
  assign nx    = nx_q;
  assign busy  = (state_q == ALIGN) || (state_q == ROUND);
  assign valid = (state_q == DONE);

endmodule

// File: doc/fpu_flt2int.md
# fpu_flt2int

Multi-cycle float-to-integer converter (FCVT.W.S / FCVT.WU.S) in the EX stage, next to the FPU's combinational int→float path. It takes a single-precision operand from ID/EX and aligns the significand iteratively, one bit per cycle. It then rounds per `flt_rm` and returns a 32-bit integer with NV/NX flags. Its `busy` is ORed into `fpu_busy` to stall the pipeline, and its result is muxed onto `fpu_res`.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous, active-low.
- `start` in 1: launch a conversion; sampled only in IDLE.
- `opa` in 32: IEEE-754 single operand; sampled with `start`.
- `ID_EX_alu_func` in 5: `` `ALU_FCVTWS `` selects signed, `` `ALU_FCVTWUS `` selects unsigned; sampled with `start`.
- `flt_rm` in 3: rounding mode, RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100; 101–111 are treated as RNE; sampled with `start`.
- `res` out 32: integer result; held until the next conversion completes.
- `nv` out 1: invalid flag; valid with `valid`, held with `res`.
- `nx` out 1: inexact flag; valid with `valid`, held with `res`.
- `busy` out 1: high when state is ALIGN or ROUND.
- `valid` out 1: one-cycle pulse in DONE.

## Operation
- **States:** IDLE → ALIGN → ROUND → DONE → IDLE. `start` is ignored outside IDLE.
- **Load (IDLE & start):**
  - Capture sign, signed/unsigned mode and rm.
  - sig = {exp≠0, mant} (24 bit; denormals have hidden bit 0).
  - E = exp − 127. mag (33 bit) = sig; guard g = 0, sticky s = 0.
- **Classify at load:**
  - exp = 255 → special. NaN (mant≠0) is treated as +∞. Skip ALIGN.
  - E ≥ 32 → overflow. Skip ALIGN.
  - E ≤ −2 → small: mag = 0, g = 0, s = (exp|mant)≠0. Skip ALIGN.
  - E in 23..31 → ALIGN left-shifts mag by 1 per cycle, for E−23 cycles.
  - E in −1..22 → ALIGN right-shifts by 1 per cycle, for 23−E cycles. Each step: s |= g; g ← mag[0]; mag >>= 1.
  - Shift count is held in a 5-bit down-counter. A count of 0 goes straight to ROUND.
- **ROUND (one cycle):**
  - inc = RNE: g&(s|mag[0]); RTZ: 0; RDN: (g|s)&sign; RUP: (g|s)&!sign; RMM: g.
  - m = mag + inc (33 bit).
  - Signed invalid: special, overflow, or m > 2^31−1 (positive) or m > 2^31 (negative).
    - Saturate to 0x7FFFFFFF if positive or NaN, else 0x80000000.
    - Otherwise res = sign ? −m : m.
  - Unsigned invalid: special, overflow, m ≥ 2^32, or (sign & m≠0).
    - Saturate to 0xFFFFFFFF if positive or NaN, else 0x00000000.
    - Otherwise res = m.
  - Zero operands (±0) yield 0, nv = 0, nx = 0.
  - nv = invalid; nx = (g|s) & !invalid.
  - Register `res`, `nv` and `nx` at the end of ROUND.
- **DONE:** `valid` = 1 for one cycle, then return to IDLE.

## Timing
- **Reset values:** state IDLE, `res` = 0, `nv` = 0, `nx` = 0, `busy` = 0, `valid` = 0.
- **Reset mid-operation:** the conversion is aborted. `busy` and `valid` are low on the cycle after the rst-low edge. No `valid` pulse is produced.
- **Latency:** `start` at edge 0 → `valid` high after edge n+2, where n is the ALIGN shift count.
  - n = 0 for special, overflow, small and E = 23 operands.
  - Maximum n = 24 (E = −1), so maximum latency is 26 cycles.
- `busy` rises after edge 0 and falls when `valid` rises. `busy` and `valid` are never both high.
- **Back-to-back:** a new `start` is accepted in the IDLE cycle following DONE. Minimum issue interval is n+3 cycles.
- **Held outputs:** `res`, `nv` and `nx` remain stable from `valid` until the next ROUND completes.

## Test plan
- **1.5 round-to-even:** 0x3FC00000, signed, RNE → `res` 0x00000002, nx = 1, nv = 0. `valid` exactly 25 cycles after `start`; `busy` high for 24 cycles.
- **−2.5 tie cases:** 0xC0200000, signed. RNE → 0xFFFFFFFE; RMM → 0xFFFFFFFD; RTZ → 0xFFFFFFFE. nx = 1 in all cases.
- **Signed/unsigned boundaries:**
  - 0x4F000000, signed → 0x7FFFFFFF, nv = 1.
  - 0xCF000000, signed → 0x80000000, nv = 0, nx = 0. Latency 10.
  - 0x4F000000, unsigned → 0x80000000, nv = 0.
- **Specials and negative unsigned:**
  - 0x7FC00000, signed → 0x7FFFFFFF, nv = 1, latency 2.
  - 0xFF800000, unsigned → 0x00000000, nv = 1.
  - 0xBF000000, unsigned, RNE → 0, nx = 1, nv = 0.
  - 0xBF000000, unsigned, RDN → 0, nv = 1, nx = 0.
- **Small and zero:**
  - 0x3E800000, RUP → 0x00000001, nx = 1, latency 2.
  - 0x80000000, signed → 0, flags 0.
  - 0x00000001 (denormal), RUP → 1.
- **Control:**
  - `start` pulsed while `busy` → ignored; the first result is unaffected.
  - `rst` low mid-ALIGN → `busy` = 0 next cycle, no `valid`, `res` = 0.
  - Conversion restarted afterwards completes normally.
